key_search_ctrl: RTL and testbench

//  Brute-force key-search sequencer for one arc4 core. Runs the core on successive
//  24-bit keys, snoops its plaintext writes, and stops at the first key whose

---
 rtl/key_search_ctrl.sv | 127 ++++++++++++
 tb/tb_key_search_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_search_ctrl.sv
// key_search_ctrl: brute-force key sequencer for a single arc4 core.
// Launches arc4 on successive keys (KEY_START, KEY_START+KEY_STEP, ...).
// Snoops the core's plaintext writes and stops at the first key whose message
// bytes (addr 1 and up) are all within [CHAR_LO, CHAR_HI].
// key_valid low with rdy high means the whole key space was tried without a hit.
module key_search_ctrl #(
   parameter logic [23:0] KEY_START = 24'h000000,
   parameter int unsigned KEY_STEP  = 1,
   parameter logic [7:0]  CHAR_LO   = 8'h20,
   parameter logic [7:0]  CHAR_HI   = 8'h7E
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        rdy,
   output logic [23:0] key,
   output logic        key_valid,
   output logic        arc_en,
   input  logic        arc_rdy,
   output logic [23:0] arc_key,
   input  logic        arc_pt_wren,
   input  logic [7:0]  arc_pt_addr,
   input  logic [7:0]  arc_pt_wrdata
);

   localparam logic [23:0] STEP     = 24'(KEY_STEP);
   // Any key above this has no successor in the 24-bit space, so it is the last one.
   localparam logic [23:0] LAST_LIM = 24'hFFFFFF - STEP;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_RUN,
      S_CHECK
   } state_t;

   // One snooped plaintext write.
   typedef struct packed {
      logic       wren;
      logic [7:0] addr;
      logic [7:0] data;
   } pt_wr_t;

   state_t      state, state_nxt;
   logic [23:0] key_nxt;
   logic        key_valid_nxt;
   logic        bad, bad_nxt;
   logic        arc_en_nxt;
   pt_wr_t      pt_wr;
   logic        byte_bad;

   assign pt_wr   = '{wren: arc_pt_wren, addr: arc_pt_addr, data: arc_pt_wrdata};
   assign arc_key = key;

   // Address 0 carries the message length and is never a character.
   assign byte_bad = pt_wr.wren && (pt_wr.addr != 8'h00) &&
                     ((pt_wr.data < CHAR_LO) || (pt_wr.data > CHAR_HI));

   // State and output registers; rdy and arc_en are registered so they are glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         rdy       <= 1'b1;
         key       <= KEY_START;
         key_valid <= 1'b0;
         arc_en    <= 1'b0;
         bad       <= 1'b0;
      end else begin
         state     <= state_nxt;
         rdy       <= (state_nxt == S_IDLE);
         key       <= key_nxt;
         key_valid <= key_valid_nxt;
         arc_en    <= arc_en_nxt;
         bad       <= bad_nxt;
      end
   end

   // Next-state and next-value logic for the search sequencer.
   always_comb begin
      state_nxt     = state;
      key_nxt       = key;
      key_valid_nxt = key_valid;
      bad_nxt       = bad;
      arc_en_nxt    = 1'b0;
      case (state)
         S_IDLE: begin
            if (en && rdy) begin
               key_nxt       = KEY_START;
               key_valid_nxt = 1'b0;
               bad_nxt       = 1'b0;
               state_nxt     = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            // arc_en is registered, so it is high during the first WAIT cycle only.
            if (arc_rdy) begin
               arc_en_nxt = 1'b1;
               state_nxt  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!arc_rdy) state_nxt = S_RUN;
         end
         S_RUN: begin
            // A write landing in the same cycle arc_rdy rises is still counted.
            if (byte_bad) bad_nxt = 1'b1;
            if (arc_rdy) state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (!bad) begin
               key_valid_nxt = 1'b1;
               state_nxt     = S_IDLE;
            end else if (key > LAST_LIM) begin
               key_valid_nxt = 1'b0;
               state_nxt     = S_IDLE;
            end else begin
               key_nxt   = key + STEP;
               bad_nxt   = 1'b0;
               state_nxt = S_LAUNCH;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_key_search_ctrl.sv
// tb_key_search_ctrl: three controllers (default, odd split, near-top split),
// each driving a behavioural arc4 model; results checked via a scoreboard.
module tb_key_search_ctrl;

   localparam int N = 3;
   localparam int BUDGET = 4000;
   localparam int M_ALLBAD = 0, M_HI = 1, M_T3 = 2, M_T4 = 3, M_BND = 4, M_ZERO = 5;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [N-1:0]        en, rdy, key_valid, arc_en, arc_rdy, pt_wren;
   logic [N-1:0][23:0]  key, arc_key;
   logic [N-1:0][7:0]   pt_addr, pt_wdata;

   int           mode = M_ALLBAD;
   int           checks = 0, errs = 0;
   int           pulses[N];
   int           m_cnt[N];
   bit           m_busy[N];
   logic [23:0]  m_key[N];
   logic [23:0]  tried[N][$];
   int           base_p[N], base_t[N];

   typedef struct {
      int          g;
      logic        valid;
      logic [23:0] key;
      int          npulse;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   key_search_ctrl u_dut0 (
      .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]), .key(key[0]),
      .key_valid(key_valid[0]), .arc_en(arc_en[0]), .arc_rdy(arc_rdy[0]),
      .arc_key(arc_key[0]), .arc_pt_wren(pt_wren[0]), .arc_pt_addr(pt_addr[0]),
      .arc_pt_wrdata(pt_wdata[0]));

   key_search_ctrl #(.KEY_START(24'h000001), .KEY_STEP(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]), .key(key[1]),
      .key_valid(key_valid[1]), .arc_en(arc_en[1]), .arc_rdy(arc_rdy[1]),
      .arc_key(arc_key[1]), .arc_pt_wren(pt_wren[1]), .arc_pt_addr(pt_addr[1]),
      .arc_pt_wrdata(pt_wdata[1]));

   key_search_ctrl #(.KEY_START(24'hFFFFF1), .KEY_STEP(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .en(en[2]), .rdy(rdy[2]), .key(key[2]),
      .key_valid(key_valid[2]), .arc_en(arc_en[2]), .arc_rdy(arc_rdy[2]),
      .arc_key(arc_key[2]), .arc_pt_wren(pt_wren[2]), .arc_pt_addr(pt_addr[2]),
      .arc_pt_wrdata(pt_wdata[2]));

   // Plaintext byte i (1..3) produced for key k under the current test mode.
   function automatic logic [7:0] pt_byte(logic [23:0] k, int i);
      case (mode)
         M_HI:  return (i == 1) ? 8'h48 : (i == 2) ? 8'h69 : 8'h21;
         M_T3:  if (k == 24'd5) return 8'(8'h60 + i);
                else return (i == 2) ? 8'h07 : 8'h61;
         M_T4:  if (k == 24'd4) return 8'h61;
                else return (i == 1) ? 8'h7F : 8'h61;
         M_BND: if (k == 24'd0) return (i == 3) ? 8'h1F : 8'h41;
                else if (k == 24'd1) return (i == 3) ? 8'h7F : 8'h41;
                else return (i == 2) ? 8'h20 : 8'h7E;
         default: return (i == 2) ? 8'h07 : 8'h61;
      endcase
   endfunction

   // Behavioural arc4: busy 20 cycles, length at addr 0, bytes at 1-3; ready rises with the last write.
   always @(posedge clk or negedge rst_n) begin
      for (int g = 0; g < N; g++) begin
         if (!rst_n) begin
            arc_rdy[g]  <= 1'b1;
            pt_wren[g]  <= 1'b0;
            pt_addr[g]  <= 8'h00;
            pt_wdata[g] <= 8'h00;
            m_busy[g]   <= 1'b0;
            m_cnt[g]    <= 0;
         end else begin
            pt_wren[g] <= 1'b0;
            if (arc_en[g]) pulses[g] <= pulses[g] + 1;
            if (!m_busy[g]) begin
               if (arc_en[g] && arc_rdy[g]) begin
                  m_busy[g]  <= 1'b1;
                  arc_rdy[g] <= 1'b0;
                  m_cnt[g]   <= 0;
                  m_key[g]   <= arc_key[g];
                  tried[g].push_back(arc_key[g]);
               end
            end else begin
               m_cnt[g] <= m_cnt[g] + 1;
               if (m_cnt[g] == 20) begin
                  pt_wren[g]  <= 1'b1;
                  pt_addr[g]  <= 8'h00;
                  pt_wdata[g] <= (mode == M_ZERO) ? 8'h00 : 8'h03;
                  if (mode == M_ZERO) begin
                     arc_rdy[g] <= 1'b1;
                     m_busy[g]  <= 1'b0;
                  end
               end else if (m_cnt[g] >= 21) begin
                  pt_wren[g]  <= 1'b1;
                  pt_addr[g]  <= 8'(m_cnt[g] - 20);
                  pt_wdata[g] <= pt_byte(m_key[g], m_cnt[g] - 20);
                  if (m_cnt[g] == 23) begin
                     arc_rdy[g] <= 1'b1;
                     m_busy[g]  <= 1'b0;
                  end
               end
            end
         end
      end
   end

   task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Push the expected result, then pulse en for one cycle.
   task automatic start(int g, logic v, logic [23:0] k, int np);
      exp_t e;
      e = '{g: g, valid: v, key: k, npulse: np};
      sb.push_back(e);
      base_p[g] = pulses[g];
      base_t[g] = tried[g].size();
      @(negedge clk) en[g] = 1'b1;
      @(negedge clk) en[g] = 1'b0;
      chk("rdy_fell", 32'(rdy[g]), 32'd0);
   endtask

   // Wait for the search to end, then pop and compare against the scoreboard.
   task automatic finish_search(int g);
      int   n = 0;
      exp_t e;
      while (rdy[g] !== 1'b1 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      chk("done_in_budget", 32'(n < BUDGET), 32'd1);
      e = sb.pop_front();
      chk("key_valid", 32'(key_valid[g]), 32'(e.valid));
      chk("key", 32'(key[g]), 32'(e.key));
      chk("arc_key", 32'(arc_key[g]), 32'(e.key));
      chk("arc_en_pulses", 32'(pulses[g] - base_p[g]), 32'(e.npulse));
   endtask

   task automatic wait_tried(int g, int cnt);
      int n = 0;
      while (tried[g].size() < cnt && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      chk("wait_tried", 32'(tried[g].size() >= cnt), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      en    = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset values.
      chk("rst_rdy", 32'(rdy[0]), 32'd1);
      chk("rst_key", 32'(key[0]), 32'd0);
      chk("rst_key_valid", 32'(key_valid[0]), 32'd0);
      chk("rst_arc_en", 32'(arc_en[0]), 32'd0);
      chk("rst_key_odd", 32'(key[1]), 32'h000001);
      chk("rst_key_top", 32'(key[2]), 32'hFFFFF1);

      // Asynchronous reset in the middle of a run on key 2.
      mode = M_ALLBAD;
      base_t[0] = tried[0].size();
      @(negedge clk) en[0] = 1'b1;
      @(negedge clk) en[0] = 1'b0;
      wait_tried(0, base_t[0] + 3);
      repeat (10) @(negedge clk);
      chk("mid_run_key", 32'(key[0]), 32'd2);
      chk("mid_run_rdy", 32'(rdy[0]), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rdy", 32'(rdy[0]), 32'd1);
      chk("async_key", 32'(key[0]), 32'd0);
      chk("async_key_valid", 32'(key_valid[0]), 32'd0);
      chk("async_arc_en", 32'(arc_en[0]), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);

      // First key is printable.
      mode = M_HI;
      start(0, 1'b1, 24'h000000, 1);
      finish_search(0);

      // Keys 0-4 bad at addr 2, key 5 good; a stray en mid-search must be ignored.
      mode = M_T3;
      start(0, 1'b1, 24'h000005, 6);
      wait_tried(0, base_t[0] + 2);
      @(negedge clk) en[0] = 1'b1;
      @(negedge clk) en[0] = 1'b0;
      chk("no_restart_rdy", 32'(rdy[0]), 32'd0);
      finish_search(0);
      for (int j = 0; j < 6; j++)
         chk("t3_seq", 32'(tried[0][base_t[0] + j]), 32'(j));

      // Re-run after success: key reloads to KEY_START.
      mode = M_HI;
      start(0, 1'b1, 24'h000000, 1);
      chk("reload_key", 32'(key[0]), 32'd0);
      chk("reload_key_valid", 32'(key_valid[0]), 32'd0);
      finish_search(0);

      // Character boundaries, checked on the write coinciding with arc_rdy rising.
      mode = M_BND;
      start(0, 1'b1, 24'h000002, 3);
      finish_search(0);

      // Zero-length message: only the length byte 0x00 is written.
      mode = M_ZERO;
      start(0, 1'b1, 24'h000000, 1);
      finish_search(0);

      // Odd half of a split search never tries key 4.
      mode = M_T4;
      base_t[1] = tried[1].size();
      @(negedge clk) en[1] = 1'b1;
      @(negedge clk) en[1] = 1'b0;
      wait_tried(1, base_t[1] + 5);
      for (int j = 0; j < 5; j++)
         chk("odd_seq", 32'(tried[1][base_t[1] + j]), 32'(1 + 2 * j));
      chk("odd_busy", 32'(rdy[1]), 32'd0);
      chk("odd_key_valid", 32'(key_valid[1]), 32'd0);
      @(negedge clk) #1 rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);

      // Exhaustion at the top of the key space.
      start(2, 1'b0, 24'hFFFFFF, 8);
      finish_search(2);
      chk("last_tried", 32'(tried[2][tried[2].size() - 1]), 32'hFFFFFF);
      chk("exhaust_rdy", 32'(rdy[2]), 32'd1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
